// File: rtl/nmr_seq_pkg.sv
// ---------------------------------------------------------------------------
// nmr_seq_pkg : shared types for the table-driven NMR pulse sequencer
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package nmr_seq_pkg;

  localparam int SEQ_TW  = 32;
  localparam int SEQ_PHW = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_PULSE = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } seq_state_t;

  typedef struct packed {
    logic [SEQ_TW-1:0]  len;
    logic [SEQ_TW-1:0]  gap;
    logic [SEQ_PHW-1:0] phase;
  } seq_entry_t;

endpackage

`default_nettype wire

// File: rtl/nmr_us_tick.sv
// ---------------------------------------------------------------------------
// nmr_us_tick : microsecond prescaler; tick is high in the last cycle of each us
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module nmr_us_tick #(
  parameter int US_DIVIDER = 125
) (
  input  logic clk,
  input  logic rst_n,
  input  logic reload,
  output logic tick
);

  localparam int              CW     = $clog2(US_DIVIDER);
  localparam logic [CW-1:0]   RELOAD = CW'(US_DIVIDER - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= RELOAD;
    end else if (reload || (r_cnt == '0)) begin
      r_cnt <= RELOAD;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign tick = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/nmr_pulse_table_sequencer.sv
// ---------------------------------------------------------------------------
// nmr_pulse_table_sequencer : table-driven RF pulse sequencer, optional
// receiver blanking when NMR_SEQ_BLANK_EN is defined.   Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module nmr_pulse_table_sequencer
  import nmr_seq_pkg::*;
#(
  parameter int US_DIVIDER = 125,
  parameter int N_ENTRIES  = 8,
  parameter int TW         = SEQ_TW,
  parameter int PHW        = SEQ_PHW,
  parameter int LW         = 16,
  localparam int AW        = $clog2(N_ENTRIES)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_en,
  input  logic [AW-1:0]  wr_addr,
  input  logic [TW-1:0]  wr_len,
  input  logic [TW-1:0]  wr_gap,
  input  logic [PHW-1:0] wr_phase,
  input  logic [AW:0]    n_entries,
  input  logic [LW-1:0]  loop_cnt,
  input  logic [TW-1:0]  blank_len,
  input  logic           start,
  input  logic           abort,
  input  logic           force_on,
  output logic           pulse_out,
  output logic [PHW-1:0] phase_out,
  output logic           sync_out,
  output logic           blank_out,
  output logic           busy,
  output logic           done
);

  localparam logic [AW:0] N_MAX = (AW + 1)'(N_ENTRIES);

  seq_entry_t     r_table [N_ENTRIES];
  seq_state_t     r_state;
  logic [AW-1:0]  r_idx;
  logic [AW:0]    r_n;
  logic [LW-1:0]  r_loop;
  logic [LW-1:0]  r_pass;
  logic [TW-1:0]  r_us;
  logic           r_pulse;
  logic [PHW-1:0] r_phase;
  logic           r_sync;
  logic           r_busy;
  logic           r_done;

  seq_entry_t     w_entry;
  logic           w_tick;
  logic           w_us_end;
  logic           w_last;
  logic           w_entry_end;

  always_ff @(posedge clk) begin
    if (wr_en && !r_busy) begin
      r_table[wr_addr] <= '{len: wr_len, gap: wr_gap, phase: wr_phase};
    end
  end

  assign w_entry  = r_table[r_idx];
  assign w_us_end = w_tick && (r_us == TW'(1));
  assign w_last   = ({1'b0, r_idx} == (r_n - 1'b1));

  // An entry finishes either in its own LOAD (empty entry) or when the last timed phase expires.
  assign w_entry_end = ((r_state == S_LOAD) && (r_n != '0) &&
                        (w_entry.len == '0) && (w_entry.gap == '0))
                    || ((r_state == S_PULSE) && w_us_end && (w_entry.gap == '0))
                    || ((r_state == S_GAP) && w_us_end);

  nmr_us_tick #(.US_DIVIDER(US_DIVIDER)) u_us_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .reload (r_state == S_LOAD),
    .tick   (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_n     <= '0;
      r_loop  <= '0;
      r_pass  <= '0;
      r_us    <= '0;
      r_pulse <= 1'b0;
      r_phase <= '0;
      r_sync  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (abort) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_pass  <= '0;
      r_us    <= '0;
      r_pulse <= 1'b0;
      r_phase <= '0;
      r_sync  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
            r_idx   <= '0;
            r_pass  <= '0;
            r_n     <= (n_entries > N_MAX) ? N_MAX : n_entries;
            r_loop  <= loop_cnt;
          end
        end
        S_LOAD: begin
          if (r_n == '0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_phase <= w_entry.phase;
            if (w_entry.len != '0) begin
              r_state <= S_PULSE;
              r_pulse <= 1'b1;
              r_us    <= w_entry.len;
              r_sync  <= (r_idx == '0) && (r_pass == '0);
            end else if (w_entry.gap != '0) begin
              r_state <= S_GAP;
              r_pulse <= 1'b0;
              r_us    <= w_entry.gap;
            end
          end
        end
        S_PULSE: begin
          if (w_us_end) begin
            r_sync <= 1'b0;
            if (w_entry.gap != '0) begin
              r_state <= S_GAP;
              r_pulse <= 1'b0;
              r_us    <= w_entry.gap;
            end
          end else if (w_tick) begin
            r_us <= r_us - 1'b1;
          end
        end
        S_GAP: begin
          if (!w_us_end && w_tick) begin
            r_us <= r_us - 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_pulse <= 1'b0;
          r_phase <= '0;
          r_idx   <= '0;
          r_pass  <= '0;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_entry_end) begin
        if (w_last && (r_pass >= r_loop)) begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end else begin
          r_state <= S_LOAD;
          r_idx   <= w_last ? '0 : r_idx + 1'b1;
          if (w_last) begin
            r_pass <= r_pass + 1'b1;
          end
        end
      end
    end
  end

  assign pulse_out = r_pulse | force_on;
  assign phase_out = r_phase;
  assign sync_out  = r_sync;
  assign busy      = r_busy;
  assign done      = r_done;

`ifdef NMR_SEQ_BLANK_EN
  logic          w_fall;
  logic          w_trig;
  logic          w_blank_tick;
  logic          r_blank;
  logic [TW-1:0] r_blank_cnt;

  // Next-edge falling of the internal gate, mirroring every path that drops r_pulse.
  always_comb begin
    w_fall = 1'b0;
    if (r_pulse) begin
      if (abort) begin
        w_fall = 1'b1;
      end else begin
        case (r_state)
          S_PULSE: w_fall = w_us_end && (w_entry.gap != '0);
          S_LOAD:  w_fall = (r_n != '0) && (w_entry.len == '0) && (w_entry.gap != '0);
          S_DONE:  w_fall = 1'b1;
          default: w_fall = 1'b0;
        endcase
      end
    end
  end

  assign w_trig = w_fall && (blank_len != '0);

  nmr_us_tick #(.US_DIVIDER(US_DIVIDER)) u_blank_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .reload (w_trig),
    .tick   (w_blank_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blank     <= 1'b0;
      r_blank_cnt <= '0;
    end else if (w_trig) begin
      r_blank     <= 1'b1;
      r_blank_cnt <= blank_len;
    end else if (r_blank && w_blank_tick) begin
      if (r_blank_cnt == TW'(1)) begin
        r_blank <= 1'b0;
      end
      r_blank_cnt <= r_blank_cnt - 1'b1;
    end
  end

  assign blank_out = r_blank;
`else
  logic w_unused_blank;
  assign w_unused_blank = ^blank_len;
  assign blank_out      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nmr_pulse_table_sequencer.sv
// ---------------------------------------------------------------------------
// tb_nmr_pulse_table_sequencer : scoreboard bench measuring pulse/blank runs
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_nmr_pulse_table_sequencer;

  localparam int DIV = 4;
  localparam int NE  = 4;
  localparam int AW  = 2;
  localparam int TW  = 32;
  localparam int PHW = 2;
  localparam int LW  = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           wr_en = 1'b0;
  logic [AW-1:0]  wr_addr = '0;
  logic [TW-1:0]  wr_len = '0;
  logic [TW-1:0]  wr_gap = '0;
  logic [PHW-1:0] wr_phase = '0;
  logic [AW:0]    n_entries = '0;
  logic [LW-1:0]  loop_cnt = '0;
  logic [TW-1:0]  blank_len = '0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic           force_on = 1'b0;
  logic           pulse_out;
  logic [PHW-1:0] phase_out;
  logic           sync_out;
  logic           blank_out;
  logic           busy;
  logic           done;

  nmr_pulse_table_sequencer #(.US_DIVIDER(DIV), .N_ENTRIES(NE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_len    (wr_len),
    .wr_gap    (wr_gap),
    .wr_phase  (wr_phase),
    .n_entries (n_entries),
    .loop_cnt  (loop_cnt),
    .blank_len (blank_len),
    .start     (start),
    .abort     (abort),
    .force_on  (force_on),
    .pulse_out (pulse_out),
    .phase_out (phase_out),
    .sync_out  (sync_out),
    .blank_out (blank_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len;
    int ph;
    int sy;
    int lo;
  } pexp_t;

  pexp_t pq[$];
  int    bq[$];
  int    n_checks = 0;
  int    n_errs = 0;
  bit    mon_en = 1'b0;
  int    done_cnt = 0;
  int    blank_hi = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void push_p(input int l, input int ph, input int sy, input int lo);
    pexp_t e;
    e.len = l; e.ph = ph; e.sy = sy; e.lo = lo;
    pq.push_back(e);
  endfunction

  // Entries {2,3,ph1},{1,0,ph2}: 8 high, 13 low (gap + LOAD), 5 high (pulse + DONE)
  function automatic void push_s1();
    push_p(8, 1, 1, -1);
    push_p(5, 2, 0, 13);
  endfunction

  // Monitor: measures each high run of pulse_out and blank_out and checks it against the queues
  logic  prev_p = 1'b0;
  logic  prev_b = 1'b0;
  int    hi_n = 0, lo_n = 0, b_n = 0, cur_ph = 0, cur_sy = 0, rec_lo = 0, bexp = 0;
  pexp_t me;

  always @(negedge clk) begin
    if (mon_en) begin
      if (done) done_cnt++;
      if (pulse_out && !prev_p) begin
        hi_n = 1; cur_ph = int'(phase_out); cur_sy = int'(sync_out); rec_lo = lo_n;
      end else if (pulse_out) begin
        hi_n++;
      end else if (prev_p) begin
        if (pq.size() == 0) begin
          check_eq("pulse_extra", hi_n, 0);
        end else begin
          me = pq.pop_front();
          check_eq("pulse_len", hi_n, me.len);
          check_eq("pulse_phase", cur_ph, me.ph);
          check_eq("pulse_sync", cur_sy, me.sy);
          if (me.lo >= 0) check_eq("pulse_low_before", rec_lo, me.lo);
        end
        lo_n = 1;
      end else begin
        lo_n++;
      end
`ifdef NMR_SEQ_BLANK_EN
      if (blank_out && !prev_b) begin
        b_n = 1;
        check_eq("blank_align", prev_p && !pulse_out, 1);
      end else if (blank_out) begin
        b_n++;
      end else if (prev_b) begin
        if (bq.size() == 0) begin
          check_eq("blank_extra", b_n, 0);
        end else begin
          bexp = bq.pop_front();
          check_eq("blank_len", b_n, bexp);
        end
      end
`else
      if (blank_out) blank_hi++;
`endif
      prev_p = pulse_out;
      prev_b = blank_out;
    end
  end

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_entry(input int a, input int l, input int g, input int p);
    wr_addr = AW'(a); wr_len = TW'(l); wr_gap = TW'(g); wr_phase = PHW'(p);
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic launch(input int n, input int lp);
    n_entries = (AW + 1)'(n);
    loop_cnt  = LW'(lp);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 400) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, busy, 0);
  endtask

  int   d0;
  int   rises;
  int   kk;
  logic pv;

  initial begin
    #1 rst_n = 1'b0;
    tick_n(3);
    check_eq("rst_pulse", pulse_out, 0);
    check_eq("rst_phase", phase_out, 0);
    check_eq("rst_sync", sync_out, 0);
    check_eq("rst_blank", blank_out, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    rst_n = 1'b1;
    tick_n(2);
    mon_en = 1'b1;

    write_entry(0, 2, 3, 1);
    write_entry(1, 1, 0, 2);
    tick_n(2);

    // single pass
    push_s1();
    d0 = done_cnt;
    launch(2, 0);
    check_eq("s1_busy", busy, 1);
    check_eq("s1_load_low", pulse_out, 0);
    tick_n(1);
    check_eq("s1_first_rise", pulse_out, 1);
    check_eq("s1_first_phase", phase_out, 1);
    wait_idle("s1_timeout");
    check_eq("s1_done_count", done_cnt - d0, 1);
    check_eq("s1_idle_phase", phase_out, 0);
    tick_n(3);

    // three passes, middle pulses merge across the gap-0 entry
    push_p(8, 1, 1, -1);
    push_p(13, 2, 0, 13);
    push_p(13, 2, 0, 13);
    push_p(5, 2, 0, 13);
    d0 = done_cnt;
    launch(2, 2);
    wait_idle("s2_timeout");
    tick_n(1);
    check_eq("s2_done_count", done_cnt - d0, 1);
    tick_n(2);

    // abort on the first cycle of entry 1's pulse
    blank_len = TW'(2);
    push_p(8, 1, 1, -1);
    push_p(1, 2, 0, 13);
`ifdef NMR_SEQ_BLANK_EN
    bq.push_back(8);
    bq.push_back(8);
`endif
    d0 = done_cnt;
    launch(2, 0);
    rises = 0; pv = 1'b0; kk = 0;
    while (rises < 2 && kk < 200) begin
      @(negedge clk);
      kk++;
      if (pulse_out && !pv) rises++;
      pv = pulse_out;
    end
    check_eq("s3_reach_entry1", rises, 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("s3_pulse", pulse_out, 0);
    check_eq("s3_busy", busy, 0);
    check_eq("s3_phase", phase_out, 0);
    tick_n(12);
    check_eq("s3_no_done", done_cnt - d0, 0);
    blank_len = '0;

    // empty table: LOAD straight to DONE
    d0 = done_cnt;
    launch(0, 0);
    check_eq("s4_busy", busy, 1);
    check_eq("s4_load_done", done, 0);
    @(negedge clk);
    check_eq("s4_done", done, 1);
    check_eq("s4_pulse", pulse_out, 0);
    @(negedge clk);
    check_eq("s4_idle_busy", busy, 0);
    check_eq("s4_idle_done", done, 0);
    check_eq("s4_done_count", done_cnt - d0, 1);
    tick_n(2);

    // table writes while busy are dropped
    push_s1();
    push_s1();
    launch(2, 0);
    tick_n(3);
    write_entry(0, 7, 1, 3);
    wait_idle("s5_run1_timeout");
    tick_n(2);
    launch(2, 0);
    wait_idle("s5_run2_timeout");
    tick_n(3);
    check_eq("s5_queue_drained", pq.size(), 0);

    // force_on and asynchronous reset mid-run
    mon_en = 1'b0;
    force_on = 1'b1;
    #1;
    check_eq("s6_force_pulse", pulse_out, 1);
    check_eq("s6_force_sync", sync_out, 0);
    @(negedge clk);
    check_eq("s6_force_hold", pulse_out, 1);
    force_on = 1'b0;
    #1;
    check_eq("s6_release_pulse", pulse_out, 0);
    tick_n(3);
    check_eq("s6_release_blank", blank_out, 0);
    launch(2, 0);
    tick_n(2);
    check_eq("s6_pre_rst_pulse", pulse_out, 1);
    check_eq("s6_pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("s6_rst_pulse", pulse_out, 0);
    check_eq("s6_rst_phase", phase_out, 0);
    check_eq("s6_rst_sync", sync_out, 0);
    check_eq("s6_rst_blank", blank_out, 0);
    check_eq("s6_rst_busy", busy, 0);
    check_eq("s6_rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick_n(2);

    check_eq("end_pulse_queue", pq.size(), 0);
    check_eq("end_blank_queue", bq.size(), 0);
    check_eq("end_blank_idle", blank_hi, 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
